// File: rtl/uop_load.sv
// uop_load: writer side of the micro-op buffer.
// Streams LOAD-UOP words into the uop SRAM write port.
//
// Ports:
//   clk, rst        clock, async active-low reset
//   cmd_*           command handshake (base address, word count)
//   in_*            micro-op word stream (valid/ready, data, last marker)
//   uop_we/waddr/   registered SRAM write port, one cycle after each beat
//   uop_wdata
//   busy            high while a command is in flight
//   done            one-cycle pulse, coincides with the final write
//   err             sticky stream framing error, cleared only by reset

module uop_load #(
    parameter int UOP_WIDTH = 32,
    parameter int UPC_WIDTH = 13,
    parameter int CNT_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [UPC_WIDTH-1:0] cmd_base,
    input  logic [CNT_WIDTH-1:0] cmd_count,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [UOP_WIDTH-1:0] in_data,
    input  logic                 in_last,

    output logic                 uop_we,
    output logic [UPC_WIDTH-1:0] uop_waddr,
    output logic [UOP_WIDTH-1:0] uop_wdata,

    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

    state_t               state;
    state_t               state_nxt;

    logic [UPC_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0] remaining;

    logic                 cmd_fire;
    logic                 beat;
    logic                 on_last;
    logic                 frame_bad;

    // Handshake qualifiers
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign beat      = in_valid & in_ready;
    assign on_last   = (remaining == CNT_ONE);

    // The producer's last marker must line up exactly with the
    // final counted word; any disagreement is a framing error.
    assign frame_bad = beat & (in_last != on_last);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;

        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    if (cmd_count == CNT_ZERO) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end

            LOAD: begin
                in_ready = 1'b1;
                if (beat && on_last) begin
                    state_nxt = DONE;
                end
            end

            DONE: begin
                // The final word's registered write lands here too.
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Address / remaining-count tracking. addr wraps naturally at
    // the SRAM size, so a full-size load covers every entry once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr      <= '0;
            remaining <= '0;
        end else if (cmd_fire) begin
            addr      <= cmd_base;
            remaining <= cmd_count;
        end else if (beat) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    // Registered SRAM write port: one cycle of latency per beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uop_we    <= 1'b0;
            uop_waddr <= '0;
            uop_wdata <= '0;
        end else begin
            uop_we <= beat;
            if (beat) begin
                uop_waddr <= addr;
                uop_wdata <= in_data;
            end
        end
    end

    // Sticky framing error; the transfer itself is not disturbed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (frame_bad) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uop_load.sv
// tb_uop_load: randomized self-checking bench for uop_load.
// Expected writes/done timing come from a transaction-level model.

module tb_uop_load;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [12:0] cmd_base = '0;
    logic [13:0] cmd_count = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        uop_we;
    logic [12:0] uop_waddr;
    logic [31:0] uop_wdata;
    logic        busy;
    logic        done;
    logic        err;

    uop_load dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_base  (cmd_base),
        .cmd_count (cmd_count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .uop_we    (uop_we),
        .uop_waddr (uop_waddr),
        .uop_wdata (uop_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [12:0] a;
        logic [31:0] d;
    } wr_t;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int last_acc = 0;

    wr_t  obs_w[$];
    wr_t  exp_w[$];
    int   obs_d[$];
    int   exp_d[$];
    bit   rdy_at[int];
    bit   busy_at[int];
    bit   inr_at[int];
    bit   err_at[int];

    logic [31:0] dat_q[$];
    bit          last_q[$];
    int          gap_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t w;
        rdy_at[cyc]  = cmd_ready;
        busy_at[cyc] = busy;
        inr_at[cyc]  = in_ready;
        err_at[cyc]  = err;
        if (uop_we === 1'b1) begin
            w.cyc = cyc;
            w.a   = uop_waddr;
            w.d   = uop_wdata;
            obs_w.push_back(w);
        end
        if (done === 1'b1) obs_d.push_back(cyc);
    end

    task automatic clear_logs();
        obs_w.delete();
        exp_w.delete();
        obs_d.delete();
        exp_d.delete();
    endtask

    task automatic prep(input int n, input int maxgap);
        dat_q.delete();
        last_q.delete();
        gap_q.delete();
        for (int i = 0; i < n; i++) begin
            dat_q.push_back($urandom);
            last_q.push_back(i == n - 1);
            gap_q.push_back($urandom_range(maxgap, 0));
        end
    endtask

    // Model: command accepted in cycle acc, stream words presented from
    // acc+1 on; word i lands at base+i mod 8192 one cycle after its beat;
    // done coincides with the last write (acc+1 for an empty command).
    task automatic run_cmd(input logic [12:0] base, input int count);
        wr_t w;
        int  lb;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_base  = base;
        cmd_count = 14'(count);
        in_valid  = 1'b0;
        last_acc  = cyc;
        lb        = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_base  = 13'($urandom);
        cmd_count = 14'($urandom);
        for (int i = 0; i < count; i++) begin
            for (int g = 0; g < gap_q[i]; g++) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                in_last  = 1'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = dat_q[i];
            in_last  = last_q[i];
            w.cyc = cyc + 1;
            w.a   = base + 13'(i);
            w.d   = dat_q[i];
            exp_w.push_back(w);
            lb = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_d.push_back(lb + 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        tests++;
        if ({uop_we, done, busy, err, in_ready} !== 5'b0) begin
            failed++;
            $display("FAIL reset_outs got %b exp 00000",
                     {uop_we, done, busy, err, in_ready});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests++;
        if (cmd_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready);
        end
    endtask

    task automatic test_basic();
        clear_logs();
        prep(3, 0);
        for (int i = 0; i < 3; i++) dat_q[i] = 32'hA0000001 + i;
        run_cmd(13'h010, 3);
        tests++;
        if (obs_w.size() != 3) begin
            failed++;
            $display("FAIL basic_nwr got %0d exp 3", obs_w.size());
        end
        for (int i = 0; i < 3 && i < obs_w.size(); i++) begin
            tests++;
            if (obs_w[i] !== exp_w[i]) begin
                failed++;
                $display("FAIL basic_wr%0d got %h exp %h", i, obs_w[i], exp_w[i]);
            end
        end
        tests++;
        if (obs_d.size() != 1 || obs_d[0] != exp_d[0]) begin
            failed++;
            $display("FAIL basic_done got n=%0d exp cyc %0d", obs_d.size(), exp_d[0]);
        end
        tests++;
        if (rdy_at[exp_d[0] + 1] !== 1'b1 || err !== 1'b0) begin
            failed++;
            $display("FAIL basic_ready_err got rdy=%b err=%b exp 1 0",
                     rdy_at[exp_d[0] + 1], err);
        end
    endtask

    task automatic test_wrap();
        clear_logs();
        prep(4, 0);
        run_cmd(13'h1FFE, 4);
        tests++;
        if (obs_w.size() != 4) begin
            failed++;
            $display("FAIL wrap_nwr got %0d exp 4", obs_w.size());
        end
        for (int i = 0; i < 4 && i < obs_w.size(); i++) begin
            tests++;
            if (obs_w[i] !== exp_w[i]) begin
                failed++;
                $display("FAIL wrap_wr%0d got %h exp %h", i, obs_w[i], exp_w[i]);
            end
        end
        tests++;
        if (obs_d.size() != 1 || obs_d[0] != exp_d[0]) begin
            failed++;
            $display("FAIL wrap_done got n=%0d exp cyc %0d", obs_d.size(), exp_d[0]);
        end
    endtask

    task automatic test_zero();
        bit saw_inr;
        clear_logs();
        prep(0, 0);
        run_cmd(13'h0AB, 0);
        saw_inr = 1'b0;
        for (int c = last_acc; c <= last_acc + 4; c++) saw_inr |= inr_at[c];
        tests++;
        if (obs_w.size() != 0 || saw_inr) begin
            failed++;
            $display("FAIL zero_nowr got nwr=%0d inr=%b exp 0 0", obs_w.size(), saw_inr);
        end
        tests++;
        if (obs_d.size() != 1 || obs_d[0] != last_acc + 1) begin
            failed++;
            $display("FAIL zero_done got n=%0d exp cyc %0d", obs_d.size(), last_acc + 1);
        end
        tests++;
        if ({busy_at[last_acc + 1], busy_at[last_acc + 2]} !== 2'b10) begin
            failed++;
            $display("FAIL zero_busy got %b exp 10",
                     {busy_at[last_acc + 1], busy_at[last_acc + 2]});
        end
    endtask

    task automatic test_gaps();
        clear_logs();
        prep(3, 0);
        gap_q[1] = 2;
        run_cmd(13'h123, 3);
        tests++;
        if (obs_w.size() != 3) begin
            failed++;
            $display("FAIL gaps_nwr got %0d exp 3", obs_w.size());
        end
        for (int i = 0; i < 3 && i < obs_w.size(); i++) begin
            tests++;
            if (obs_w[i] !== exp_w[i]) begin
                failed++;
                $display("FAIL gaps_wr%0d got %h exp %h", i, obs_w[i], exp_w[i]);
            end
        end
        tests++;
        if (obs_d.size() != 1 || obs_d[0] != exp_d[0]) begin
            failed++;
            $display("FAIL gaps_done got n=%0d exp cyc %0d", obs_d.size(), exp_d[0]);
        end
    endtask

    task automatic test_random();
        int bad;
        clear_logs();
        for (int k = 0; k < 8; k++) begin
            int n;
            n = $urandom_range(12, 1);
            prep(n, 2);
            run_cmd(13'($urandom), n);
        end
        tests++;
        if (obs_w.size() != exp_w.size()) begin
            failed++;
            $display("FAIL rand_nwr got %0d exp %0d", obs_w.size(), exp_w.size());
        end
        bad = 0;
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++)
            if (obs_w[i] !== exp_w[i]) bad++;
        tests++;
        if (bad != 0) begin
            failed++;
            $display("FAIL rand_writes got %0d bad exp 0", bad);
        end
        bad = (obs_d.size() == exp_d.size()) ? 0 : 1;
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++)
            if (obs_d[i] != exp_d[i]) bad++;
        tests++;
        if (bad != 0 || err !== 1'b0) begin
            failed++;
            $display("FAIL rand_done got bad=%0d err=%b exp 0 0", bad, err);
        end
    endtask

    task automatic test_max();
        int bad;
        bit hit[8192];
        clear_logs();
        prep(8192, 0);
        run_cmd(13'h0777, 8192);
        bad = (obs_w.size() == 8192) ? 0 : 1;
        for (int i = 0; i < 8192; i++) hit[i] = 1'b0;
        for (int i = 0; i < obs_w.size(); i++) begin
            if (i < exp_w.size() && obs_w[i] !== exp_w[i]) bad++;
            hit[obs_w[i].a] = 1'b1;
        end
        for (int i = 0; i < 8192; i++) if (!hit[i]) bad++;
        tests++;
        if (bad != 0) begin
            failed++;
            $display("FAIL max_writes got %0d bad (nwr=%0d) exp 0", bad, obs_w.size());
        end
        tests++;
        if (obs_d.size() != 1 || obs_d[0] != exp_d[0]) begin
            failed++;
            $display("FAIL max_done got n=%0d exp cyc %0d", obs_d.size(), exp_d[0]);
        end
    endtask

    task automatic test_framing();
        int acc1;
        int bad;
        clear_logs();
        prep(2, 0);
        last_q[0] = 1'b1;
        last_q[1] = 1'b0;
        run_cmd(13'h040, 2);
        acc1 = last_acc;
        tests++;
        if ({err_at[acc1 + 1], err_at[acc1 + 2]} !== 2'b01) begin
            failed++;
            $display("FAIL frame_err_rise got %b exp 01",
                     {err_at[acc1 + 1], err_at[acc1 + 2]});
        end
        prep(1, 0);
        run_cmd(13'h050, 1);
        bad = (obs_w.size() == 3 && obs_d.size() == 2) ? 0 : 1;
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++)
            if (obs_w[i] !== exp_w[i]) bad++;
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++)
            if (obs_d[i] != exp_d[i]) bad++;
        tests++;
        if (bad != 0) begin
            failed++;
            $display("FAIL frame_writes got %0d bad exp 0", bad);
        end
        tests++;
        if (err !== 1'b1 || err_at[last_acc + 1] !== 1'b1) begin
            failed++;
            $display("FAIL frame_err_sticky got %b exp 1", err);
        end
    endtask

    task automatic test_reset_mid();
        wr_t w;
        int bad;
        clear_logs();
        prep(5, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_base  = 13'h100;
        cmd_count = 14'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = dat_q[i];
            in_last  = 1'b0;
            w.cyc = cyc + 1;
            w.a   = 13'h100 + 13'(i);
            w.d   = dat_q[i];
            exp_w.push_back(w);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        tests++;
        if ({uop_we, done, busy, err} !== 4'b0) begin
            failed++;
            $display("FAIL rstmid_outs got %b exp 0000", {uop_we, done, busy, err});
        end
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = $urandom;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failed++;
            $display("FAIL rstmid_ready got rdy=%b busy=%b exp 1 0", cmd_ready, busy);
        end
        repeat (3) begin
            @(posedge clk); #1;
            in_data = $urandom;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        bad = (obs_w.size() == 2 && obs_d.size() == 0) ? 0 : 1;
        for (int i = 0; i < 2 && i < obs_w.size(); i++)
            if (obs_w[i] !== exp_w[i]) bad++;
        tests++;
        if (bad != 0) begin
            failed++;
            $display("FAIL rstmid_writes got nwr=%0d ndone=%0d bad=%0d exp 2 0 0",
                     obs_w.size(), obs_d.size(), bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero();
        test_gaps();
        test_random();
        test_max();
        test_framing();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uop_load.md
Name: uop_load

Overview:
- Writer side of the micro-op buffer: takes a LOAD-UOP command (SRAM base, count) and a stream of 32-bit micro-op words, and writes them into the uop SRAM.
- The GEMM micro-op fetch unit later reads these entries by upc.
- Sits between the load DMA stream and the uop SRAM write port.
- Reports completion with a done pulse and flags stream framing errors.

Parameters:
UOP_WIDTH, 32, micro-op word width ([10:0] acc idx, [21:11] inp idx, [31:22] wgt idx)
UPC_WIDTH, 13, uop SRAM address width (8192 entries)
CNT_WIDTH, 14, command count width (0..8192)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
cmd_valid  input  1  command valid
cmd_ready  output  1  command accepted when high with cmd_valid
cmd_base  input  UPC_WIDTH  first SRAM address to write
cmd_count  input  CNT_WIDTH  number of micro-ops to write
in_valid  input  1  stream word valid
in_ready  output  1  stream word accepted when high with in_valid
in_data  input  UOP_WIDTH  micro-op word
in_last  input  1  producer marks final word of command
uop_we  output  1  SRAM write enable
uop_waddr  output  UPC_WIDTH  SRAM write address
uop_wdata  output  UOP_WIDTH  SRAM write data
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
err  output  1  sticky framing error; cleared only by reset

Behaviour:
- Reset (rst low, asynchronous) forces:
  - state IDLE;
  - all outputs 0, except cmd_ready, which follows from IDLE (1 once rst is high);
  - addr and remaining counters 0.
- Reset mid-LOAD aborts the command. No further uop_we after rst is asserted.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - cmd_ready = 1, in_ready = 0.
  - On cmd_valid: addr <= cmd_base, remaining <= cmd_count.
  - Next state is DONE if cmd_count == 0, else LOAD.
- LOAD:
  - cmd_ready = 0, in_ready = 1. A beat is in_valid && in_ready.
  - On each beat:
    - next cycle uop_we = 1, uop_waddr = addr, uop_wdata = in_data (1-cycle registered latency);
    - addr <= addr + 1, wrapping modulo 2^UPC_WIDTH (8191 -> 0);
    - remaining <= remaining - 1.
  - Beat with remaining == 1 -> DONE.
  - No beat -> uop_we = 0 next cycle; counters hold.
- DONE:
  - done = 1 for exactly this one cycle; cmd_ready = 0, in_ready = 0; next state IDLE.
  - The final word's uop_we occurs in the same cycle as done.
- Framing error: err <= 1 (sticky) if either
  - in_last = 1 on a beat with remaining != 1, or
  - in_last = 0 on a beat with remaining == 1.
  - The word is still written and the count still governs termination; a framing error does not stop the transfer.
- Count 0: no stream words are consumed, no writes occur, done pulses one cycle after acceptance, err is unaffected.
- Count 8192 (max): writes every SRAM entry once, starting at cmd_base and wrapping.
- A new command is never accepted in LOAD or DONE. Minimum command spacing is count + 2 cycles.
- in_data and in_last are ignored when not in LOAD.
- busy = (state != IDLE), registered as part of the state.

Test Plan:
- Reset, then cmd_base=0x010, cmd_count=3; in_valid continuous with data 0xA0000001, 0xA0000002, 0xA0000003; in_last on the 3rd word.
  -> uop_we at addrs 0x010, 0x011, 0x012 with matching data on consecutive cycles; done=1 with the 3rd write; err=0; cmd_ready returns 1 the next cycle.
- cmd_base=0x1FFE, cmd_count=4.
  -> writes to 0x1FFE, 0x1FFF, 0x000, 0x001 in that order; done once.
- cmd_count=0.
  -> in_ready never high, no uop_we, done pulses exactly one cycle after acceptance, busy high for 1 cycle.
- cmd_count=3, with in_valid deasserted for 2 cycles between words 1 and 2.
  -> exactly 3 writes, no write during gaps, addresses contiguous, done after 3rd beat.
- cmd_count=2 with in_last on word 1, then a new command of count 1 with correct in_last.
  -> both commands write all words; err=1 after the first beat and stays 1 through the second command.
- Assert rst low after 2 of 5 beats.
  -> uop_we=0, done=0, busy=0 immediately; cmd_ready=1 after rst high; no residual writes.
